// File: rtl/qvga_frame_reader.sv
// -----------------------------------------------------------------------------
// qvga_frame_reader
//
// Reads a 320x240 RGB565 frame buffer and produces a 640x480@60 VGA stream.
// Each stored pixel is shown as a 2x2 block. The 16-bit RGB565 word is reduced
// to RGB444 by keeping the top four bits of each channel.
//
// Data path:
//   counters (stage 0) -> rAddr register -> RAM (RD_LATENCY cycles)
//                      -> colour/sync output registers
// Counter state to outputs takes RD_LATENCY+2 cycles. The sync, enable and
// frame-start flags go through a shift pipeline of the same depth, so they
// stay aligned with the colours.
//
// Ports:
//   clk          pixel clock, 25 MHz
//   reset_n      asynchronous active-low reset, released synchronously
//   rAddr[16:0]  frame-buffer read address, 0..76799 (registered)
//   rData[15:0]  frame-buffer read data, RGB565, valid RD_LATENCY cycles
//                after rAddr
//   h_sync       horizontal sync, active low
//   v_sync       vertical sync, active low
//   de           display enable, high for visible pixels
//   red/green/blue[3:0]  RGB444 colour, zero outside the visible area
//   frame_start  one-cycle pulse together with output pixel (0,0)
//
// Build option:
//   FRAME_BORDER_EN  when defined, the outermost visible rows and columns are
//                    forced to white (4'hF on every channel). Read addresses
//                    do not change.
//
// RD_LATENCY may be 1, 2 or 3.
// -----------------------------------------------------------------------------
module qvga_frame_reader #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [16:0] rAddr,
   input  logic [15:0] rData,
   output logic        h_sync,
   output logic        v_sync,
   output logic        de,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        frame_start
);

   localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int LINE_WORDS = H_ACTIVE / 2;       // stored pixels per line
   localparam int PIPE_DEPTH = RD_LATENCY + 1;     // rAddr stage + RAM latency
   localparam int LAST       = PIPE_DEPTH - 1;

   // Flags generated at stage 0 for one pixel. They travel with that pixel's
   // read request.
   typedef struct packed {
      logic active;
      logic hs;      // active low, same polarity as h_sync
      logic vs;      // active low, same polarity as v_sync
      logic first;   // counter state (0,0)
   } flags_t;

   localparam flags_t FLAGS_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1, first: 1'b0};

   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic [16:0] line_base;
   flags_t      flags0;
   flags_t      pipe [PIPE_DEPTH];

   // The low bits of each RGB565 field are dropped by the RGB444 mapping.
   logic rdata_unused;
   assign rdata_unused = ^{rData[11], rData[6:5], rData[0]};

   // ---------------------------------------------------------------------------
   // Stage 0: decode the current counter position
   // ---------------------------------------------------------------------------
   // NOTE: every field gets a value before any condition is evaluated, so this
   // block cannot infer a latch.
   always_comb begin
      flags0        = FLAGS_IDLE;
      flags0.active = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
      flags0.hs     = !((h_cnt >= 10'(H_ACTIVE + H_FP)) &&
                        (h_cnt <  10'(H_ACTIVE + H_FP + H_SYNC)));
      flags0.vs     = !((v_cnt >= 10'(V_ACTIVE + V_FP)) &&
                        (v_cnt <  10'(V_ACTIVE + V_FP + V_SYNC)));
      flags0.first  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
   end

   // ---------------------------------------------------------------------------
   // Counters, line base and read address
   // ---------------------------------------------------------------------------
   // NOTE: all state uses non-blocking assignments, so each register samples
   // the values from before the edge and the evaluation order of blocks does
   // not matter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt     <= '0;
         v_cnt     <= '0;
         line_base <= '0;
         rAddr     <= '0;
      end else begin
         // Dropping h_cnt[0] repeats each stored pixel on two output pixels.
         rAddr <= flags0.active ? (line_base + 17'(h_cnt[9:1])) : '0;

         if (h_cnt == 10'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            if (v_cnt == 10'(V_TOTAL - 1)) begin
               v_cnt     <= '0;
               line_base <= '0;
            end else begin
               v_cnt <= v_cnt + 10'd1;
               // Advance after odd lines only, so each stored line is shown twice.
               if (v_cnt[0] && (v_cnt < 10'(V_ACTIVE)))
                  line_base <= line_base + 17'(LINE_WORDS);
            end
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Flag pipeline. Stage 0 is captured with rAddr. The last stage lines up
   // with the cycle in which rData belongs to that address.
   // ---------------------------------------------------------------------------
   // NOTE: this array is a shift pipeline, not a RAM. It is reset so that no
   // stale sync or enable pulse appears after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= FLAGS_IDLE;
      end else begin
         pipe[0] <= flags0;
         for (int i = 1; i < PIPE_DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

`ifdef FRAME_BORDER_EN
   // Border membership is decided at stage 0 and delayed like the other flags.
   logic                  border0;
   logic [PIPE_DEPTH-1:0] border_pipe;

   assign border0 = flags0.active &&
                    ((h_cnt == 10'd0) || (h_cnt == 10'(H_ACTIVE - 1)) ||
                     (v_cnt == 10'd0) || (v_cnt == 10'(V_ACTIVE - 1)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) border_pipe <= '0;
      else          border_pipe <= {border_pipe[PIPE_DEPTH-2:0], border0};
   end
`endif

   // ---------------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_sync      <= 1'b1;
         v_sync      <= 1'b1;
         de          <= 1'b0;
         frame_start <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
      end else begin
         h_sync      <= pipe[LAST].hs;
         v_sync      <= pipe[LAST].vs;
         de          <= pipe[LAST].active;
         frame_start <= pipe[LAST].first;
         if (pipe[LAST].active) begin
            red   <= rData[15:12];
            green <= rData[10:7];
            blue  <= rData[4:1];
         end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end
`ifdef FRAME_BORDER_EN
         if (border_pipe[LAST]) begin
            red   <= 4'hF;
            green <= 4'hF;
            blue  <= 4'hF;
         end
`endif
      end
   end

endmodule

// File: tb/tb_qvga_frame_reader.sv
// -----------------------------------------------------------------------------
// tb_qvga_frame_reader
//
// Two instances run side by side:
//   A: full 640x480 timing, RD_LATENCY=1, checked over the first three lines.
//   B: reduced 16x8 geometry, RD_LATENCY=3, checked over two whole frames
//      (frame wrap, last address, frame_start spacing).
// The expected pixel stream is queued when reset is released. Monitors pop
// and compare one entry whenever de is high. Sync, enable, frame_start and
// rAddr are compared every cycle against the timing formulas.
// -----------------------------------------------------------------------------
module tb_qvga_frame_reader;

   localparam int A_LAT   = 1;
   localparam int A_HT    = 800;
   localparam int A_LINES = 3;
   localparam int A_LIMIT = A_LINES * A_HT + A_LAT + 1;

   localparam int B_HA = 16, B_HFP = 2, B_HS = 3, B_HBP = 3;
   localparam int B_VA = 8,  B_VFP = 1, B_VS = 2, B_VBP = 1;
   localparam int B_LAT   = 3;
   localparam int B_HT    = B_HA + B_HFP + B_HS + B_HBP;   // 24
   localparam int B_VT    = B_VA + B_VFP + B_VS + B_VBP;   // 12
   localparam int B_FRAME = B_HT * B_VT;                   // 288
   localparam int B_LIMIT = 2 * B_FRAME + B_LAT + 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [16:0] raddr_a, raddr_b;
   logic [15:0] rdata_a, rdata_b, b_d1, b_d2, b_d3;
   logic        hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
   logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;

   int n_cmp = 0;
   int n_bad = 0;
   logic armed = 1'b0;
   int k = 0;

   logic [11:0] q_a[$];
   logic [11:0] q_b[$];

   int fs_a_cnt = 0, fs_a_first = -1;
   int fs_b_cnt = 0, fs_b_first = -1, fs_b_second = -1;
   int de_a_cnt = 0, hs_a_low = 0, hs_a_first = -1;
   int de_b_cnt = 0, vs_b_low = 0, hs_b_low = 0;

   qvga_frame_reader #(.RD_LATENCY(A_LAT)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .rAddr(raddr_a), .rData(rdata_a),
      .h_sync(hs_a), .v_sync(vs_a), .de(de_a),
      .red(red_a), .green(green_a), .blue(blue_a), .frame_start(fs_a)
   );

   qvga_frame_reader #(
      .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
      .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
      .RD_LATENCY(B_LAT)
   ) u_dut_b (
      .clk(clk), .reset_n(reset_n), .rAddr(raddr_b), .rData(rdata_b),
      .h_sync(hs_b), .v_sync(vs_b), .de(de_b),
      .red(red_b), .green(green_b), .blue(blue_b), .frame_start(fs_b)
   );

   // Frame-buffer contents. Addresses 0 and 1 hold magenta and green.
   // All other words are a fixed scramble of the address.
   function automatic logic [15:0] ram_word(input logic [16:0] a);
      logic [31:0] t;
      if (a == 17'd0) return 16'hF81F;
      if (a == 17'd1) return 16'h07E0;
      t = 32'(a) * 32'd40503 + 32'd4660;
      return t[15:0];
   endfunction

   // Synchronous RAM models: latency 1 for A, latency 3 for B.
   always @(posedge clk) rdata_a <= ram_word(raddr_a);
   always @(posedge clk) begin
      b_d1 <= ram_word(raddr_b);
      b_d2 <= b_d1;
      b_d3 <= b_d2;
   end
   assign rdata_b = b_d3;

   // Expected RGB444 for output pixel (x,y) in a ha x va display.
   function automatic logic [11:0] exp_pixel(input int x, input int y, input int ha, input int va);
      int a;
      logic [15:0] w;
      a = (y / 2) * (ha / 2) + x / 2;
`ifdef FRAME_BORDER_EN
      if (x == 0 || x == ha - 1 || y == 0 || y == va - 1) return 12'hFFF;
`endif
      if (a == 0) return 12'hF0F;     // F81F -> R=F G=0 B=F
      if (a == 1) return 12'h0F0;     // 07E0 -> R=0 G=F B=0
      w = ram_word(17'(a));
      return {w[15:12], w[10:7], w[4:1]};
   endfunction

   task automatic check(input string name, input int at, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at sample %0d: got %0h, expected %0h", name, at, act, exp);
      end
   endtask

   // Sample s is taken on the falling edge after the s-th rising edge that
   // follows reset release. rAddr then reflects counter state s-1, and the
   // outputs reflect counter state s-(lat+2).
   task automatic check_timing(input string tag, input int s, input int lat,
                               input int ha, input int hfp, input int hsw, input int hbp,
                               input int va, input int vfp, input int vsw, input int vbp,
                               input logic [16:0] addr, input logic hsy, input logic vsy,
                               input logic dev, input logic fs, input logic [11:0] rgb);
      int ht, vt, n, h, v, ea;
      logic eh, ev, ed, ef;
      ht = ha + hfp + hsw + hbp;
      vt = va + vfp + vsw + vbp;
      n = s - 1;
      h = n % ht;
      v = (n / ht) % vt;
      ea = (h < ha && v < va) ? (v / 2) * (ha / 2) + h / 2 : 0;
      check({tag, ".rAddr"}, s, 32'(addr), 32'(ea));
      n = s - (lat + 2);
      if (n < 0) begin
         eh = 1'b1; ev = 1'b1; ed = 1'b0; ef = 1'b0;
      end else begin
         h = n % ht;
         v = (n / ht) % vt;
         eh = !(h >= ha + hfp && h < ha + hfp + hsw);
         ev = !(v >= va + vfp && v < va + vfp + vsw);
         ed = (h < ha && v < va);
         ef = (h == 0 && v == 0);
      end
      check({tag, ".h_sync"}, s, 32'(hsy), 32'(eh));
      check({tag, ".v_sync"}, s, 32'(vsy), 32'(ev));
      check({tag, ".de"}, s, 32'(dev), 32'(ed));
      check({tag, ".frame_start"}, s, 32'(fs), 32'(ef));
      if (!dev) check({tag, ".blank_rgb"}, s, 32'(rgb), 32'd0);
   endtask

   task automatic check_reset_state(input string tag, input int s, input logic [16:0] addr,
                                    input logic hsy, input logic vsy, input logic dev,
                                    input logic fs, input logic [11:0] rgb);
      check({tag, ".rst_rAddr"}, s, 32'(addr), 32'd0);
      check({tag, ".rst_h_sync"}, s, 32'(hsy), 32'd1);
      check({tag, ".rst_v_sync"}, s, 32'(vsy), 32'd1);
      check({tag, ".rst_de"}, s, 32'(dev), 32'd0);
      check({tag, ".rst_frame_start"}, s, 32'(fs), 32'd0);
      check({tag, ".rst_rgb"}, s, 32'(rgb), 32'd0);
   endtask

   always @(posedge clk) begin
      if (!armed) k <= 0;
      else        k <= k + 1;
   end

   // Monitor A
   always @(negedge clk) begin
      if (armed && k >= 1 && k <= A_LIMIT) begin
         check_timing("A", k, A_LAT, 640, 16, 96, 48, 480, 10, 2, 33,
                      raddr_a, hs_a, vs_a, de_a, fs_a, {red_a, green_a, blue_a});
         if (fs_a) begin
            fs_a_cnt++;
            if (fs_a_first < 0) fs_a_first = k;
         end
         if (!hs_a) begin
            hs_a_low++;
            if (hs_a_first < 0) hs_a_first = k;
         end
         if (de_a) begin
            de_a_cnt++;
            if (q_a.size() == 0) check("A.pixel_queue_empty", k, 32'(q_a.size()), 32'd1);
            else check("A.pixel", k, 32'({red_a, green_a, blue_a}), 32'(q_a.pop_front()));
         end
      end
   end

   // Monitor B
   always @(negedge clk) begin
      if (armed && k >= 1 && k <= B_LIMIT) begin
         check_timing("B", k, B_LAT, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP,
                      raddr_b, hs_b, vs_b, de_b, fs_b, {red_b, green_b, blue_b});
         if (fs_b) begin
            fs_b_cnt++;
            if (fs_b_first < 0) fs_b_first = k;
            else if (fs_b_second < 0) fs_b_second = k;
         end
         if (!hs_b) hs_b_low++;
         if (!vs_b) vs_b_low++;
         if (de_b) begin
            de_b_cnt++;
            if (q_b.size() == 0) check("B.pixel_queue_empty", k, 32'(q_b.size()), 32'd1);
            else check("B.pixel", k, 32'({red_b, green_b, blue_b}), 32'(q_b.pop_front()));
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      // Let A run into the middle of line 0, then abort with a 10-cycle reset.
      repeat (300) @(negedge clk);
      reset_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         check_reset_state("A", i, raddr_a, hs_a, vs_a, de_a, fs_a, {red_a, green_a, blue_a});
         check_reset_state("B", i, raddr_b, hs_b, vs_b, de_b, fs_b, {red_b, green_b, blue_b});
         @(negedge clk);
      end

      // Expected pixel streams, in raster order.
      for (int y = 0; y < A_LINES; y++)
         for (int x = 0; x < 640; x++) q_a.push_back(exp_pixel(x, y, 640, 480));
      for (int f = 0; f < 2; f++)
         for (int y = 0; y < B_VA; y++)
            for (int x = 0; x < B_HA; x++) q_b.push_back(exp_pixel(x, y, B_HA, B_VA));

      armed   = 1'b1;
      reset_n = 1'b1;
      repeat (A_LIMIT + 5) @(negedge clk);

      check("A.pixels_left", A_LIMIT, 32'(q_a.size()), 32'd0);
      check("B.pixels_left", B_LIMIT, 32'(q_b.size()), 32'd0);
      check("A.frame_start_count", A_LIMIT, 32'(fs_a_cnt), 32'd1);
      check("A.frame_start_first", A_LIMIT, 32'(fs_a_first), 32'(A_LAT + 2));
      check("A.de_count", A_LIMIT, 32'(de_a_cnt), 32'(A_LINES * 640));
      check("A.h_sync_low_count", A_LIMIT, 32'(hs_a_low), 32'(A_LINES * 96));
      check("A.h_sync_first_low", A_LIMIT, 32'(hs_a_first), 32'(656 + A_LAT + 2));
      check("B.frame_start_count", B_LIMIT, 32'(fs_b_cnt), 32'd2);
      check("B.frame_start_first", B_LIMIT, 32'(fs_b_first), 32'(B_LAT + 2));
      check("B.frame_period", B_LIMIT, 32'(fs_b_second - fs_b_first), 32'(B_FRAME));
      check("B.de_count", B_LIMIT, 32'(de_b_cnt), 32'(2 * B_HA * B_VA));
      check("B.v_sync_low_count", B_LIMIT, 32'(vs_b_low), 32'(2 * B_VS * B_HT));
      check("B.h_sync_low_count", B_LIMIT, 32'(hs_b_low), 32'(2 * B_VT * B_HS));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/qvga_frame_reader.md
Name: qvga_frame_reader

Overview:
- Display-side counterpart of the camera capture path: reads the 320x240 RGB565 frame buffer and drives a 640x480@60 VGA output.
- Generates VGA timing and the matching frame-buffer read addresses, doubling each stored pixel 2x2 and converting RGB565 to RGB444.
- Sits between the frame-buffer read port (synchronous RAM) and the board VGA connector.
- Runs on the 25 MHz pixel clock domain.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- RD_LATENCY, 1, frame-buffer read latency in cycles (legal 1..3)

Ports:
- clk  in  1  pixel clock, 25 MHz
- reset_n  in  1  asynchronous active-low reset
- rAddr  out  17  frame-buffer read address (0..76799)
- rData  in  16  frame-buffer read data, RGB565, valid RD_LATENCY cycles after rAddr
- h_sync  out  1  horizontal sync, active low
- v_sync  out  1  vertical sync, active low
- de  out  1  display enable, high for visible pixels
- red  out  4  red channel
- green  out  4  green channel
- blue  out  4  blue channel
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Reset (async assert, sync release): h_cnt=0, v_cnt=0, line_base=0, rAddr=0, h_sync=1, v_sync=1, de=0, red/green/blue=0, frame_start=0. All pipeline stages are cleared.
- Reset mid-frame: aborts immediately. The first post-reset cycle is counter state (0,0).
- Counters:
  - h_cnt 0..H_TOTAL-1 (800), wraps to 0 and increments v_cnt.
  - v_cnt 0..V_TOTAL-1 (525), wraps to 0.
  - Frame period is 420000 cycles.
- Stage-0 active flag: h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- Stage-0 sync:
  - hs low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Address generation:
  - line_base advances by 320 when h_cnt==H_TOTAL-1 and v_cnt[0]==1 and v_cnt<V_ACTIVE.
  - line_base returns to 0 at frame wrap.
  - rAddr is registered: line_base + h_cnt[9:1] when active, else 0.
  - Each source pixel is therefore read on two consecutive cycles and on two consecutive lines.
- Pipeline:
  - rAddr is valid 1 cycle after counter state.
  - rData returns RD_LATENCY cycles later.
  - Colour outputs are registered 1 cycle after rData.
  - Total latency from counter state to outputs: RD_LATENCY+2 cycles.
  - active, hs, vs and the (0,0) flag pass through an identical-depth shift pipeline, so de/h_sync/v_sync/frame_start stay exactly aligned with the colours.
- Colour mapping:
  - When pipelined active=1: red=rData[15:12], green=rData[10:7], blue=rData[4:1].
  - When active=0: all channels are 0, regardless of rData.
- frame_start: high for exactly one cycle per frame, coincident with de rising for pixel (0,0).
- Arithmetic: line_base and rAddr are 17 bits unsigned. The maximum in-range value is 76799, so no wrap occurs in normal operation.

Optional Feature:
- Macro: FRAME_BORDER_EN.
- Defined: output pixels with x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 force red=green=blue=4'hF while de=1. Border position is evaluated at stage 0 and pipelined. rAddr sequencing is unchanged.
- Undefined: no border logic is present; all visible pixels come from rData.

Test Plan:
- Reset: hold reset_n=0 for 10 cycles mid-line -> h_sync=1, v_sync=1, de=0, colours 0, rAddr=0. After release, frame_start pulses at cycle RD_LATENCY+2.
- Address sequence: observe line 0 -> rAddr = 0,0,1,1,...,319,319 over h_cnt 0..639, then 0 for 160 blanking cycles. Line 1 repeats 0..319; line 2 starts at 320. Pixel (639,479) -> rAddr=76799.
- Data alignment: RAM model with RD_LATENCY=1 returns 16'hF81F at addr 0 and 16'h07E0 at addr 1 -> first four de cycles give (F,0,F),(F,0,F),(0,F,0),(0,F,0). Repeat with RD_LATENCY=3 -> same alignment.
- Sync timing: per line, h_sync low for exactly 96 cycles starting 656+RD_LATENCY+2 cycles after h_cnt=0. v_sync low for exactly 1600 cycles (lines 490-491). de high for 640 cycles per line, 480 lines per frame.
- Frame wrap: run 2 frames -> frame_start pulses exactly 420000 cycles apart; line_base returns to 0 and rAddr restarts at 0.
- FRAME_BORDER_EN defined, RAM all 16'h0000 -> pixels at x=0/639 or y=0/479 output F,F,F; interior pixels output 0,0,0. Without the macro -> all 0.
